// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between port A and port B.
// One operation in flight: accept (IDLE) -> execute (EXEC) -> return result (RESP).
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             a_req_valid,
  output logic             a_req_ready,
  input  logic [3:0]       a_req_op,
  input  logic [WIDTH-1:0] a_req_srca,
  input  logic [WIDTH-1:0] a_req_srcb,
  output logic             a_rsp_valid,
  input  logic             a_rsp_ready,
  output logic [WIDTH-1:0] a_rsp_result,

  input  logic             b_req_valid,
  output logic             b_req_ready,
  input  logic [3:0]       b_req_op,
  input  logic [WIDTH-1:0] b_req_srca,
  input  logic [WIDTH-1:0] b_req_srcb,
  output logic             b_rsp_valid,
  input  logic             b_rsp_ready,
  output logic [WIDTH-1:0] b_rsp_result,

  output logic [3:0]       alu_operation,
  output logic [WIDTH-1:0] alu_srca,
  output logic [WIDTH-1:0] alu_srcb,
  input  logic [WIDTH-1:0] alu_result,

  output logic             busy
);

  localparam int unsigned OP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [OP_W-1:0]  r_op;
  logic [WIDTH-1:0] r_srca;
  logic [WIDTH-1:0] r_srcb;
  logic [WIDTH-1:0] r_result;
  logic             r_owner_b;
  logic             r_prio_b;

  logic             w_idle;
  logic             w_pick_b;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_rsp_hs;

  // B wins when it is the only requester or when it holds priority.
  assign w_idle    = (r_state == ST_IDLE);
  assign w_pick_b  = b_req_valid && (!a_req_valid || r_prio_b);
  assign w_grant_a = w_idle && a_req_valid && !w_pick_b;
  assign w_grant_b = w_idle && w_pick_b;
  assign w_rsp_hs  = (r_state == ST_RESP) && (r_owner_b ? b_rsp_ready : a_rsp_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_op      <= '0;
      r_srca    <= '0;
      r_srcb    <= '0;
      r_result  <= '0;
      r_owner_b <= 1'b0;
      r_prio_b  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_grant_a || w_grant_b) begin
            r_op      <= w_grant_b ? b_req_op   : a_req_op;
            r_srca    <= w_grant_b ? b_req_srca : a_req_srca;
            r_srcb    <= w_grant_b ? b_req_srcb : a_req_srcb;
            r_owner_b <= w_grant_b;
            r_state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_result <= alu_result;
          r_state  <= ST_RESP;
        end
        ST_RESP: begin
          // Priority moves to the other port only once the result is taken.
          if (w_rsp_hs) begin
            r_prio_b <= !r_owner_b;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign a_req_ready   = w_grant_a;
  assign b_req_ready   = w_grant_b;
  assign a_rsp_valid   = (r_state == ST_RESP) && !r_owner_b;
  assign b_rsp_valid   = (r_state == ST_RESP) &&  r_owner_b;
  assign a_rsp_result  = r_result;
  assign b_rsp_result  = r_result;
  assign alu_operation = r_op;
  assign alu_srca      = r_srca;
  assign alu_srcb      = r_srcb;
  assign busy          = !w_idle;

`ifndef SYNTHESIS
  a_one_grant : assert property (@(posedge clk) disable iff (reset)
    !(a_req_ready && b_req_ready));
  a_one_rsp : assert property (@(posedge clk) disable iff (reset)
    !(a_rsp_valid && b_rsp_valid));
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter against a transaction-level model with its own ALU.
module tb_alu_arbiter;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
  logic             b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [3:0]       a_req_op, b_req_op, alu_operation;
  logic [WIDTH-1:0] a_req_srca, a_req_srcb, a_rsp_result;
  logic [WIDTH-1:0] b_req_srca, b_req_srcb, b_rsp_result;
  logic [WIDTH-1:0] alu_srca, alu_srcb, alu_result;
  logic             busy;

  alu_arbiter #(.WIDTH(WIDTH)) u_dut (
    .clk(clk), .reset(reset),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_op(a_req_op),
    .a_req_srca(a_req_srca), .a_req_srcb(a_req_srcb),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_result(a_rsp_result),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_op(b_req_op),
    .b_req_srca(b_req_srca), .b_req_srcb(b_req_srcb),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_result(b_rsp_result),
    .alu_operation(alu_operation), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .alu_result(alu_result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference ALU; reserved codes get an arbitrary but deterministic mix.
  function automatic logic [WIDTH-1:0] alu_f(input logic [3:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a << b[4:0];
      4'b0100: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b0110: return a - b;
      4'b1000: return WIDTH'(a == b);
      4'b1010: return WIDTH'($signed(a) >>> b[4:0]);
      4'b1100: return WIDTH'($signed(a) < $signed(b));
      default: return a ^ {b[15:0], b[31:16]} ^ WIDTH'(op);
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_operation, alu_srca, alu_srcb);

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Pending request per port (0 = A, 1 = B)
  logic             pend   [2];
  logic [3:0]       pend_op[2];
  logic [WIDTH-1:0] pend_a [2];
  logic [WIDTH-1:0] pend_b [2];
  logic             rr     [2];

  // Model of the transaction in flight
  logic             m_inflight = 1'b0;
  int               m_owner    = 0;
  int               m_prio     = 0;
  int               m_acc      = 0;
  int               m_ops      = 0;
  int               m_skips[2] = '{0, 0};
  logic             m_after_rst = 1'b0;
  logic [3:0]       l_op;
  logic [WIDTH-1:0] l_a, l_b;
  logic [3:0]       legal[10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'hA, 4'hC};

  task automatic set_req(input int p, input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    pend[p] = 1'b1; pend_op[p] = op; pend_a[p] = a; pend_b[p] = b;
  endtask

  task automatic step(input int p_req, input int p_rr, input int p_rst);
    logic exp_rdy[2];
    logic act_rdy[2];
    logic act_vld[2];
    logic [WIDTH-1:0] act_res[2];
    int   d;
    int   g;
    @(posedge clk);
    #1;
    reset = (p_rst > 0) && ($urandom_range(99) < p_rst);
    for (int p = 0; p < 2; p++) begin
      if (!pend[p] && p_req > 0 && $urandom_range(99) < p_req)
        set_req(p, ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : legal[$urandom_range(9)],
                $urandom, ($urandom_range(1) == 0) ? WIDTH'($urandom_range(40)) : WIDTH'($urandom));
      rr[p] = (p_rr > 0) && ($urandom_range(99) < p_rr);
    end
    a_req_valid = pend[0] && !reset; a_req_op = pend_op[0]; a_req_srca = pend_a[0]; a_req_srcb = pend_b[0];
    b_req_valid = pend[1] && !reset; b_req_op = pend_op[1]; b_req_srca = pend_a[1]; b_req_srcb = pend_b[1];
    a_rsp_ready = rr[0];
    b_rsp_ready = rr[1];
    @(negedge clk);
    act_rdy[0] = a_req_ready; act_rdy[1] = b_req_ready;
    act_vld[0] = a_rsp_valid; act_vld[1] = b_rsp_valid;
    act_res[0] = a_rsp_result; act_res[1] = b_rsp_result;
    if (reset) begin
      m_inflight  = 1'b0;
      m_prio      = 0;
      m_skips     = '{0, 0};
      m_after_rst = 1'b1;
    end else begin
      check("busy", WIDTH'(busy), WIDTH'(m_inflight));
      if (m_after_rst) begin
        check("rst_alu_op", WIDTH'(alu_operation), '0);
        check("rst_alu_srca", alu_srca, '0);
        check("rst_alu_srcb", alu_srcb, '0);
        check("rst_rsp_result", a_rsp_result, '0);
        m_after_rst = 1'b0;
      end
      if (m_inflight) begin
        d = cyc - m_acc;
        exp_rdy = '{1'b0, 1'b0};
        check("alu_op", WIDTH'(alu_operation), WIDTH'(l_op));
        check("alu_srca", alu_srca, l_a);
        check("alu_srcb", alu_srcb, l_b);
        for (int p = 0; p < 2; p++)
          check(p == 0 ? "a_rsp_valid" : "b_rsp_valid", WIDTH'(act_vld[p]),
                WIDTH'(d >= 2 && m_owner == p));
        if (d >= 2)
          check(m_owner == 0 ? "a_rsp_result" : "b_rsp_result", act_res[m_owner], alu_f(l_op, l_a, l_b));
      end else begin
        exp_rdy[0] = pend[0] && (!pend[1] || m_prio == 0);
        exp_rdy[1] = pend[1] && (!pend[0] || m_prio == 1);
        check("a_rsp_valid_idle", WIDTH'(act_vld[0]), '0);
        check("b_rsp_valid_idle", WIDTH'(act_vld[1]), '0);
      end
      check("a_req_ready", WIDTH'(act_rdy[0]), WIDTH'(exp_rdy[0]));
      check("b_req_ready", WIDTH'(act_rdy[1]), WIDTH'(exp_rdy[1]));
      // Advance the model: response handshake or new grant
      if (m_inflight) begin
        if (cyc - m_acc >= 2 && rr[m_owner]) begin
          m_inflight = 1'b0;
          m_prio     = 1 - m_owner;
          m_ops++;
        end
      end else if (exp_rdy[0] || exp_rdy[1]) begin
        g = exp_rdy[1] ? 1 : 0;
        if (pend[1 - g]) m_skips[1 - g]++;
        check("starve_bound", WIDTH'(m_skips[g] <= 1), WIDTH'(1));
        m_skips[g] = 0;
        m_inflight = 1'b1;
        m_owner    = g;
        m_acc      = cyc;
        l_op = pend_op[g]; l_a = pend_a[g]; l_b = pend_b[g];
        pend[g] = 1'b0;
      end
    end
    cyc++;
  endtask

  initial begin
    pend = '{1'b0, 1'b0};
    pend_op = '{4'h0, 4'h0}; pend_a = '{'0, '0}; pend_b = '{'0, '0};
    rr = '{1'b0, 1'b0};
    reset = 1'b1;
    a_req_valid = 1'b0; a_req_op = '0; a_req_srca = '0; a_req_srcb = '0; a_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_op = '0; b_req_srca = '0; b_req_srcb = '0; b_rsp_ready = 1'b0;
    repeat (2) step(0, 100, 100);
    check("add_5_7_ref", alu_f(4'b0010, 32'd5, 32'd7), 32'd12);

    set_req(0, 4'b0010, 32'd5, 32'd7);
    repeat (6) step(0, 100, 0);

    set_req(0, 4'b0110, 32'd10, 32'd3);
    set_req(1, 4'b0100, 32'hF0, 32'hFF);
    repeat (8) step(0, 100, 0);
    set_req(0, 4'b0001, 32'h3, 32'h4);
    set_req(1, 4'b0000, 32'hF, 32'h5);
    repeat (8) step(0, 100, 0);

    repeat (30) step(100, 100, 0);
    repeat (6) step(0, 100, 0);

    set_req(0, 4'b1100, 32'hFFFF_FFFE, 32'd1);
    set_req(1, 4'b0011, 32'd1, 32'd4);
    repeat (7) step(0, 0, 0);
    repeat (8) step(0, 100, 0);

    set_req(0, 4'b0010, 32'd1, 32'd2);
    step(0, 100, 0);
    step(0, 100, 100);
    set_req(0, 4'b0010, 32'd3, 32'd4);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 100);
    set_req(0, 4'b0101, 32'h80, 32'd3);
    set_req(1, 4'b0110, 32'd9, 32'd2);
    repeat (10) step(0, 100, 0);

    set_req(1, 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (5) step(0, 100, 0);

    repeat (1000) step(60, 60, 2);
    repeat (1000) step(100, 30, 1);
    repeat (1000) step(25, 90, 0);
    check("ops_completed", WIDTH'(m_ops > 100), WIDTH'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
